// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, runtime parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each sample point.
module uart_rx_cfg #(
   parameter int N_BITS_DATA  = 8,
   parameter int OVERSAMPLE   = 16,
   parameter int N_CONT_TICKS = 4,
   parameter int N_CONT_BITS  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_ticks,
   input  logic                   rx_data,
   input  logic [1:0]             cfg_parity,
   input  logic                   cfg_stop2,
   output logic [N_BITS_DATA-1:0] data_o,
   output logic                   rx_done_tick,
   output logic                   parity_err,
   output logic                   frame_err
);

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      START  = 5'b00010,
      DATA   = 5'b00100,
      PARITY = 5'b01000,
      STOP   = 5'b10000
   } state_t;

   localparam int S_IDLE   = 0;
   localparam int S_START  = 1;
   localparam int S_DATA   = 2;
   localparam int S_PARITY = 3;
   localparam int S_STOP   = 4;

   localparam logic [N_CONT_TICKS-1:0] SP   = N_CONT_TICKS'(OVERSAMPLE/2 - 1);
   localparam logic [N_CONT_TICKS-1:0] LAST = N_CONT_TICKS'(OVERSAMPLE - 1);
   localparam logic [N_CONT_BITS-1:0]  BLAST = N_CONT_BITS'(N_BITS_DATA - 1);

   state_t                   state, state_n;
   logic [N_CONT_TICKS-1:0]  tick_cnt, tick_n;
   logic [N_CONT_BITS-1:0]   bit_cnt, bit_n;
   logic [N_BITS_DATA-1:0]   shift_reg, shift_n;
   logic [1:0]               par_lat, par_n;
   logic                     stop2_lat, stop2_n;
   logic                     perr, perr_n;
   logic                     ferr, ferr_n;
   logic                     done_pend, pend_n;
   logic [N_CONT_TICKS-1:0]  dec_tick;
   logic                     at_dec;
   logic                     bit_val;
   logic                     par_en;
   logic                     par_exp;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [N_CONT_TICKS-1:0] START_DEC = SP + 1'b1;
   logic [1:0] vote;

   // Two votes are captured on the ticks just before the decision tick.
   always_ff @(posedge clock) begin
      if (!reset)
         vote <= '0;
      else if (s_ticks &&
               (tick_cnt == dec_tick - N_CONT_TICKS'(2) ||
                tick_cnt == dec_tick - N_CONT_TICKS'(1)))
         vote <= {vote[0], rx_data};
   end

   assign bit_val = (vote[1] & vote[0]) | (vote[1] & rx_data) |
                    (vote[0] & rx_data);
`else
   localparam logic [N_CONT_TICKS-1:0] START_DEC = SP;
   assign bit_val = rx_data;
`endif

   // After START the counter restarts, so later decisions land on the wrap.
   assign dec_tick = state[S_START] ? START_DEC : LAST;
   assign at_dec   = (tick_cnt == dec_tick);
   assign par_en   = (par_lat == 2'b01) || (par_lat == 2'b10);
   assign par_exp  = (par_lat == 2'b10) ? ~(^shift_reg) : ^shift_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_lat   <= '0;
         stop2_lat <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         done_pend <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_n;
         bit_cnt   <= bit_n;
         shift_reg <= shift_n;
         par_lat   <= par_n;
         stop2_lat <= stop2_n;
         perr      <= perr_n;
         ferr      <= ferr_n;
         done_pend <= pend_n;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      bit_n   = bit_cnt;
      shift_n = shift_reg;
      par_n   = par_lat;
      stop2_n = stop2_lat;
      perr_n  = perr;
      ferr_n  = ferr;
      pend_n  = 1'b0;
      if (s_ticks) begin
         tick_n = tick_cnt + 1'b1;
         unique case (1'b1)
            state[S_IDLE]: begin
               tick_n = '0;
               bit_n  = '0;
               if (!rx_data) begin
                  state_n = START;
                  par_n   = cfg_parity;
                  stop2_n = cfg_stop2;
                  perr_n  = 1'b0;
                  ferr_n  = 1'b0;
               end
            end
            state[S_START]: begin
               if (at_dec) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  state_n = bit_val ? IDLE : DATA;
               end
            end
            state[S_DATA]: begin
               if (at_dec) begin
                  tick_n  = '0;
                  shift_n = {bit_val, shift_reg[N_BITS_DATA-1:1]};
                  if (bit_cnt == BLAST) begin
                     bit_n   = '0;
                     state_n = par_en ? PARITY : STOP;
                  end else begin
                     bit_n = bit_cnt + 1'b1;
                  end
               end
            end
            state[S_PARITY]: begin
               if (at_dec) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  perr_n  = (bit_val != par_exp);
                  state_n = STOP;
               end
            end
            state[S_STOP]: begin
               if (at_dec) begin
                  tick_n = '0;
                  ferr_n = ferr | ~bit_val;
                  if (stop2_lat && bit_cnt == '0) begin
                     bit_n = N_CONT_BITS'(1);
                  end else begin
                     bit_n   = '0;
                     state_n = IDLE;
                     pend_n  = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               tick_n  = '0;
               bit_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         data_o       <= '0;
         rx_done_tick <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= done_pend;
         if (done_pend) begin
            data_o     <= shift_reg;
            parity_err <= perr;
            frame_err  <= ferr;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed plus randomized frames for uart_rx_cfg.
// Expected words and flags come from a frame-level model.
module tb_uart_rx_cfg;
  localparam int NB   = 8;
  localparam int OS   = 16;
  localparam int SP   = OS/2 - 1;
  localparam int TDIV = 4;
  localparam int TCLK = 10;
  localparam longint WDOG = 64'd20_000_000;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = SP + 2;
`else
  localparam int DEC = SP + 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          s_ticks = 1'b0;
  logic          rx_data = 1'b1;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic [NB-1:0] data_o;
  logic          rx_done_tick;
  logic          parity_err;
  logic          frame_err;

  int            vec = 0;
  int            err = 0;
  int            done_cnt = 0;
  longint        done_t = 0;
  longint        sp_t = 0;
  longint        fsp_t = 0;
  logic [NB-1:0] done_q[$];
  longint        done_tq[$];

  uart_rx_cfg dut (
    .clock        (clock),
    .reset        (reset),
    .s_ticks      (s_ticks),
    .rx_data      (rx_data),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .data_o       (data_o),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #(TCLK/2) clock = ~clock;

  initial begin : tickgen
    int c;
    c = 0;
    forever begin
      @(negedge clock);
      s_ticks = (c == 0);
      c = (c + 1) % TDIV;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (rx_done_tick === 1'b1) begin
        done_cnt++;
        done_t = $time;
        done_q.push_back(data_o);
        done_tq.push_back($time);
      end
    end
  end

  initial begin : watchdog
    #(WDOG);
    err++;
    $error("FAIL timeout: stimulus did not finish");
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    if (obs !== exp) begin
      err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(negedge clock);
    rx_data = b;
    for (int i = 0; i < n; i++) begin
      do @(posedge clock); while (s_ticks !== 1'b1);
      if (i == DEC) sp_t = $time;
    end
  endtask

  function automatic logic model_perr(
    input logic [NB-1:0] d,
    input logic [1:0] p,
    input logic pb);
    case (p)
      2'b01:   return pb != (^d);
      2'b10:   return pb != ~(^d);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_frame(
    input logic [NB-1:0] d, input logic [1:0] par,
    input logic st2, input logic pb,
    input logic s1, input logic s2);
    @(negedge clock);
    cfg_parity = par;
    cfg_stop2  = st2;
    drive_bit(1'b0, OS);
    @(negedge clock);
    cfg_parity = 2'($urandom);
    cfg_stop2  = 1'($urandom);
    for (int i = 0; i < NB; i++) drive_bit(d[i], OS);
    if (par == 2'b01 || par == 2'b10) drive_bit(pb, OS);
    drive_bit(s1, (s1 || st2) ? OS : DEC + 1);
    if (st2) drive_bit(s2, s2 ? OS : DEC + 1);
    fsp_t = sp_t;
  endtask

  task automatic check_frame(
    input string tag, input logic [NB-1:0] d,
    input logic pe, input logic fe, input int n0);
    #1;
    chk({tag, ".count"}, done_cnt, n0 + 1);
    chk({tag, ".data"}, data_o, d);
    chk({tag, ".perr"}, parity_err, pe);
    chk({tag, ".ferr"}, frame_err, fe);
    chk({tag, ".latency"}, done_t,
        fsp_t + longint'(TCLK + TCLK/2));
  endtask

  initial begin : stim
    int            n0;
    int            q0;
    logic [NB-1:0] d;
    logic [1:0]    p;
    logic          st2, pb, s1, s2;
    logic [NB-1:0] w0, w1;
    longint        dt;

    repeat (5) @(negedge clock);
    #1;
    vec++;
    if (data_o !== 8'h00 || rx_done_tick !== 1'b0 ||
        parity_err !== 1'b0 || frame_err !== 1'b0) begin
      err++;
      $error("FAIL rst: data %0h done %b perr %b ferr %b",
             data_o, rx_done_tick, parity_err, frame_err);
    end
    @(negedge clock);
    reset = 1'b1;
    drive_bit(1'b1, 2*OS);

    n0 = done_cnt;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    check_frame("a5_8n1", 8'hA5, 1'b0, 1'b0, n0);

    n0 = done_cnt;
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    check_frame("even_ok", 8'h3C, 1'b0, 1'b0, n0);

    n0 = done_cnt;
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    check_frame("even_bad", 8'h3C, 1'b1, 1'b0, n0);

    n0 = done_cnt;
    send_frame(8'h81, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 2*OS);
    check_frame("odd_stop2", 8'h81, 1'b0, 1'b1, n0);

    n0 = done_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2*OS);
    #1;
    chk("glitch.count", done_cnt, n0);
    chk("glitch.data", data_o, 8'h81);
    chk("glitch.perr", parity_err, 1'b0);
    chk("glitch.ferr", frame_err, 1'b1);

    n0 = done_cnt;
    q0 = done_q.size();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hAA, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    #1;
    w0 = (done_q.size() > q0) ? done_q[q0] : 'x;
    w1 = (done_q.size() > q0 + 1) ? done_q[q0+1] : 'x;
    dt = (done_tq.size() > q0 + 1) ?
         done_tq[q0+1] - done_tq[q0] : -1;
    chk("b2b.count", done_cnt, n0 + 2);
    chk("b2b.first", w0, 8'h55);
    chk("b2b.second", w1, 8'hAA);
    chk("b2b.spacing", dt, longint'(10*OS*TDIV*TCLK));

    n0 = done_cnt;
    @(negedge clock);
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    drive_bit(1'b0, OS);
    repeat (3) drive_bit(1'b1, OS);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("abort.data", data_o, 8'h00);
    chk("abort.perr", parity_err, 1'b0);
    chk("abort.ferr", frame_err, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive_bit(1'b1, 2*OS);
    #1;
    chk("abort.count", done_cnt, n0);
    send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    check_frame("after_abort", 8'h12, 1'b0, 1'b0, n0);

`ifdef UART_RX_MAJORITY_EN
    n0 = done_cnt;
    @(negedge clock);
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    drive_bit(1'b0, OS);
    repeat (3) drive_bit(1'b0, OS);
    drive_bit(1'b0, DEC - 1);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, OS - DEC);
    repeat (4) drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b1, 2*OS);
    #1;
    chk("spike.count", done_cnt, n0 + 1);
    chk("spike.data", data_o, 8'h00);
    chk("spike.ferr", frame_err, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      d   = NB'($urandom);
      p   = 2'($urandom_range(0, 3));
      st2 = 1'($urandom);
      pb  = 1'($urandom);
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      n0  = done_cnt;
      send_frame(d, p, st2, pb, s1, s2);
      drive_bit(1'b1, 2*OS);
      check_frame($sformatf("rnd%0d", k), d,
                  model_perr(d, p, pb),
                  !s1 || (st2 && !s2), n0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule
